// File: rtl/oem_block_merger_if.sv
// Handshake bundle for the block merger: block-in stream and element-out stream.
// The slave side is the merger itself; the master side is the upstream/downstream.
interface oem_block_merger_if #(
  parameter int DW  = 6,
  parameter int BLK = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DW*BLK-1:0] blk_in;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;

  modport master (
    output in_valid, blk_in, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, blk_in, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/oem_block_merger.sv
// Captures two sorted 16-element blocks and streams them out as one sorted
// 32-element run, one element per handshake.
//
// state  | meaning
// LOAD_A | waiting for the first block, stored into bank A
// LOAD_B | waiting for the second block, stored into bank B
// MERGE  | emitting the smaller bank head each handshake, ties favour A
module oem_block_merger #(
  parameter int DW  = 6,
  parameter int BLK = 16
) (
  input  logic               clk,
  input  logic               rst,
  oem_block_merger_if.slave  bus
);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, MERGE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] a [BLK];
  logic [DW-1:0] b [BLK];
  logic [4:0]    ia, ib;
  logic          rdy;
  logic          in_fire, out_fire, sel_a, last;
  logic [DW-1:0] a_head, b_head;

  assign a_head   = a[ia[3:0]];
  assign b_head   = b[ib[3:0]];
  // A pointer at 16 means A is exhausted; a B pointer at 16 forces A.
  assign sel_a    = ib[4] | (~ia[4] & (a_head <= b_head));
  assign last     = (state == MERGE) && (({1'b0, ia} + {1'b0, ib}) == 6'd31);
  assign in_fire  = rdy & bus.in_valid;
  assign out_fire = (state == MERGE) & bus.out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A:  if (in_fire) state_nxt = LOAD_B;
      LOAD_B:  if (in_fire) state_nxt = MERGE;
      MERGE:   if (out_fire && last) state_nxt = LOAD_A;
      default: state_nxt = LOAD_A;
    endcase
  end

  // in_ready is registered so it stays low for every cycle rst is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_A;
      rdy   <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy   <= (state_nxt != MERGE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ia <= '0;
      ib <= '0;
      for (int k = 0; k < BLK; k++) begin
        a[k] <= '0;
        b[k] <= '0;
      end
    end else begin
      if (state == LOAD_A && in_fire) begin
        for (int k = 0; k < BLK; k++) a[k] <= bus.blk_in[DW*k +: DW];
        ia <= '0;
      end
      if (state == LOAD_B && in_fire) begin
        for (int k = 0; k < BLK; k++) b[k] <= bus.blk_in[DW*k +: DW];
        ib <= '0;
      end
      if (out_fire) begin
        if (sel_a) ia <= ia + 5'd1;
        else       ib <= ib + 5'd1;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state == MERGE);
  assign bus.out_data  = (state == MERGE) ? (sel_a ? a_head : b_head) : '0;
  assign bus.out_last  = last;

endmodule

// File: tb/tb_oem_block_merger.sv
// Directed-plus-random bench for oem_block_merger; expected runs come from a
// stable sort of the tagged elements of both blocks.
module tb_oem_block_merger;
  localparam int DW  = 6;
  localparam int BLK = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  oem_block_merger_if #(.DW(DW), .BLK(BLK)) bus ();

  oem_block_merger #(.DW(DW), .BLK(BLK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int blk_a [16];
  int blk_b [16];
  int exp_d [32];
  int exp_s [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*BLK-1:0] pack_sel(input bit sel_b);
    logic [DW*BLK-1:0] v;
    int e;
    v = '0;
    for (int j = 0; j < 16; j++) begin
      e = sel_b ? blk_b[j] : blk_a[j];
      v[DW*j +: DW] = e[DW-1:0];
    end
    return v;
  endfunction

  // Key = value, then source (A before B), then position: a stable merge order.
  function automatic void build_model();
    int kq[$];
    for (int j = 0; j < 16; j++) begin
      kq.push_back((blk_a[j] << 5) | j);
      kq.push_back((blk_b[j] << 5) | 16 | j);
    end
    kq.sort();
    for (int i = 0; i < 32; i++) begin
      exp_d[i] = kq[i] >> 5;
      exp_s[i] = (kq[i] >> 4) & 1;
    end
  endfunction

  task automatic rand_pair();
    int qa[$];
    int qb[$];
    for (int i = 0; i < 16; i++) begin
      qa.push_back(int'($urandom_range(0, 63)));
      qb.push_back(int'($urandom_range(0, 63)));
    end
    qa.sort();
    qb.sort();
    for (int i = 0; i < 16; i++) begin
      blk_a[i] = qa[i];
      blk_b[i] = qb[i];
    end
  endtask

  task automatic load_pair(input string tag);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.blk_in   = pack_sel(1'b0);
    while (bus.in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check({tag, " wait_in_ready"}, 32'(n < 100), 1);
    step();
    check({tag, " in_ready_loadb"}, bus.in_ready, 1);
    check({tag, " no_valid_loadb"}, bus.out_valid, 0);
    bus.blk_in = pack_sel(1'b1);
    step();
    bus.in_valid = 1'b0;
    check({tag, " first_valid"}, bus.out_valid, 1);
    build_model();
  endtask

  task automatic drain(input string tag, input bit rnd_ready, output int cycles);
    int k, pia, pib;
    bit stalled;
    logic [DW-1:0] sd;
    logic sl;
    logic [4:0] sia, sib;
    k = 0;
    cycles = 0;
    stalled = 1'b0;
    sd = '0;
    sl = 1'b0;
    sia = '0;
    sib = '0;
    while (k < 32 && cycles < 400) begin
      bus.out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      check({tag, " out_valid"}, bus.out_valid, 1);
      check({tag, " in_ready_merge"}, bus.in_ready, 0);
      if (stalled) begin
        check({tag, " hold_data"}, bus.out_data, sd);
        check({tag, " hold_last"}, bus.out_last, sl);
        check({tag, " hold_ia"}, dut.ia, sia);
        check({tag, " hold_ib"}, dut.ib, sib);
      end
      if (bus.out_ready) begin
        check({tag, " data"}, bus.out_data, exp_d[k]);
        check({tag, " last"}, bus.out_last, 32'(k == 31));
        pia = int'(dut.ia);
        pib = int'(dut.ib);
        step();
        cycles++;
        check({tag, " ia_step"}, dut.ia, pia + (exp_s[k] == 0 ? 1 : 0));
        check({tag, " ib_step"}, dut.ib, pib + (exp_s[k] == 1 ? 1 : 0));
        k++;
        stalled = 1'b0;
      end else begin
        sd = bus.out_data;
        sl = bus.out_last;
        sia = dut.ia;
        sib = dut.ib;
        stalled = 1'b1;
        step();
        cycles++;
      end
    end
    check({tag, " handshakes"}, k, 32);
    check({tag, " in_ready_after"}, bus.in_ready, 1);
    check({tag, " valid_after"}, bus.out_valid, 0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    bus.in_valid  = 1'b1;
    bus.blk_in    = '1;
    bus.out_ready = 1'b1;

    // Reset with in_valid high: the block offered during reset is ignored.
    rst = 1'b1;
    step();
    check("rst in_ready", bus.in_ready, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_last", bus.out_last, 0);
    check("rst out_data", bus.out_data, 0);
    check("rst ia", dut.ia, 0);
    check("rst ib", dut.ib, 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    step();
    check("post_rst in_ready", bus.in_ready, 1);
    check("post_rst out_valid", bus.out_valid, 0);

    // Basic merge at full rate.
    for (int i = 0; i < 16; i++) begin
      blk_a[i] = i;
      blk_b[i] = 16 + i;
    end
    load_pair("basic");
    drain("basic", 1'b0, cyc);
    check("basic cycles", cyc, 32);

    // Interleaved blocks alternate banks every element.
    for (int i = 0; i < 16; i++) begin
      blk_a[i] = 2 * i;
      blk_b[i] = 2 * i + 1;
    end
    load_pair("interleave");
    for (int i = 0; i < 32; i++) check("interleave model", exp_s[i], i % 2);
    drain("interleave", 1'b0, cyc);

    // Ties drain all of A first; extreme value closes the run.
    for (int i = 0; i < 16; i++) begin
      blk_a[i] = 7;
      blk_b[i] = (i == 15) ? 63 : 7;
    end
    load_pair("ties");
    drain("ties", 1'b0, cyc);
    check("ties final", exp_d[31], 63);

    // Backpressure on the basic pair.
    for (int i = 0; i < 16; i++) begin
      blk_a[i] = i;
      blk_b[i] = 16 + i;
    end
    load_pair("bp");
    drain("bp", 1'b1, cyc);

    // New block held on the input during a merge becomes the next A.
    load_pair("stall");
    rand_pair();
    bus.in_valid = 1'b1;
    bus.blk_in   = pack_sel(1'b0);
    drain("stall", 1'b0, cyc);
    load_pair("stall_next");
    drain("stall_next", 1'b0, cyc);

    // Reset after 10 elements aborts the run.
    for (int i = 0; i < 16; i++) begin
      blk_a[i] = i;
      blk_b[i] = 16 + i;
    end
    load_pair("midrst");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("midrst data", bus.out_data, exp_d[i]);
      step();
    end
    rst = 1'b1;
    step();
    check("midrst out_valid", bus.out_valid, 0);
    check("midrst in_ready_low", bus.in_ready, 0);
    check("midrst out_data", bus.out_data, 0);
    rst = 1'b0;
    step();
    check("midrst in_ready", bus.in_ready, 1);
    check("midrst valid_idle", bus.out_valid, 0);
    rand_pair();
    load_pair("midrst_fresh");
    drain("midrst_fresh", 1'b0, cyc);

    // Random sorted pairs under random backpressure.
    for (int r = 0; r < 4; r++) begin
      rand_pair();
      load_pair("rand");
      drain("rand", 1'b1, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
